// File: rtl/off_chip_link_credit.sv
// Off-chip link model: words are serialised into LINK_W beats, carried through a
// credit-controlled link FIFO and reassembled into words on the receive side.
module off_chip_link_credit #(
   parameter int DATA_W  = 8,
   parameter int LINK_W  = 4,
   parameter int DEPTH   = 8,
   parameter int CREDITS = DEPTH,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  credit_cnt,
   output logic [CNT_W-1:0]  fifo_level,
   output logic              overflow_err
);

   localparam int BEATS = DATA_W / LINK_W;
   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BEATS - 1);
   localparam logic [CNT_W-1:0] CRED_INIT = CNT_W'(CREDITS);
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

   typedef enum logic {IDLE, SEND} tx_state_t;

   tx_state_t          state_q;
   logic [DATA_W-1:0]  word_q;
   logic [IDX_W-1:0]   idx_q;

   logic [CNT_W-1:0]   credit_q, credit_d;
   logic               ret_q;

   logic [LINK_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   level_q, level_d;
   logic               ovf_q;

   logic [DATA_W-1:0]  asm_q, asm_d;
   logic [IDX_W-1:0]   rx_idx_q, rx_idx_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;

   logic               tx_wr, tx_last, hs;
   logic [LINK_W-1:0]  tx_beat, rd_beat;
   logic               full, empty, pop, push;

   // ---------------- transmit side ----------------
   assign tx_wr    = (state_q == SEND) && (credit_q != '0);
   assign tx_last  = (idx_q == LAST_IDX);
   assign in_ready = !rst && ((state_q == IDLE) || (tx_wr && tx_last));
   assign hs       = in_valid && in_ready;
   assign tx_beat  = word_q[idx_q*LINK_W +: LINK_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hs) begin
                  word_q  <= in_data;
                  idx_q   <= '0;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (tx_wr) begin
                  if (tx_last) begin
                     idx_q <= '0;
                     // A handshake on the last beat keeps the link busy with no bubble.
                     if (hs) word_q <= in_data;
                     else    state_q <= IDLE;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // ---------------- credits ----------------
   always_comb begin
      credit_d = credit_q;
      if (tx_wr && !ret_q)
         credit_d = credit_q - CNT_W'(1);
      else if (!tx_wr && ret_q && (credit_q < CRED_INIT))
         credit_d = credit_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credit_q <= CRED_INIT;
         ret_q    <= 1'b0;
      end else begin
         credit_q <= credit_d;
         ret_q    <= pop;
      end
   end

   // ---------------- link FIFO ----------------
   assign full    = (level_q == DEPTH_C);
   assign empty   = (level_q == '0);
   assign rd_beat = mem_q[rd_ptr_q];
   assign pop     = !empty && !(out_valid_q && !out_ready);
   assign push    = tx_wr && (!full || pop);

   always_comb begin
      level_d = level_q;
      if (push && !pop)
         level_d = level_q + CNT_W'(1);
      else if (pop && !push)
         level_d = level_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= tx_beat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
         if (tx_wr && full && !pop) ovf_q <= 1'b1;
      end
   end

   // ---------------- receive side ----------------
   always_comb begin
      asm_d       = asm_q;
      rx_idx_d    = rx_idx_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (pop) begin
         asm_d[rx_idx_q*LINK_W +: LINK_W] = rd_beat;
         if (rx_idx_q == LAST_IDX) begin
            rx_idx_d    = '0;
            out_data_d  = asm_d;
            out_valid_d = 1'b1;
         end else begin
            rx_idx_d = rx_idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         asm_q       <= '0;
         rx_idx_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         asm_q       <= asm_d;
         rx_idx_q    <= rx_idx_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data     = out_data_q;
   assign out_valid    = out_valid_q;
   assign credit_cnt   = credit_q;
   assign fifo_level   = level_q;
   assign overflow_err = ovf_q;

endmodule

// File: tb/tb_off_chip_link_credit.sv
// Bench for off_chip_link_credit: default, single-credit and wide instances,
// table vectors, directed corner cases and a randomized scoreboard run.
module tb_off_chip_link_credit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // default instance
   logic [7:0] in_data = '0, out_data;
   logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, overflow_err;
   logic [3:0] credit_cnt, fifo_level;

   // CREDITS=1 instance
   logic [7:0] c1_in_data = '0, c1_out_data;
   logic       c1_in_valid = 1'b0, c1_in_ready, c1_out_valid, c1_out_ready = 1'b0, c1_ovf;
   logic [3:0] c1_credit, c1_level;

   // wide instance
   logic [31:0] w_in_data = '0, w_out_data;
   logic        w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b0, w_ovf;
   logic [2:0]  w_credit, w_level;

   off_chip_link_credit u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .credit_cnt(credit_cnt), .fifo_level(fifo_level), .overflow_err(overflow_err));

   off_chip_link_credit #(.CREDITS(1)) u_c1 (
      .clk(clk), .rst(rst), .in_data(c1_in_data), .in_valid(c1_in_valid), .in_ready(c1_in_ready),
      .out_data(c1_out_data), .out_valid(c1_out_valid), .out_ready(c1_out_ready),
      .credit_cnt(c1_credit), .fifo_level(c1_level), .overflow_err(c1_ovf));

   off_chip_link_credit #(.DATA_W(32), .LINK_W(8), .DEPTH(4)) u_wide (
      .clk(clk), .rst(rst), .in_data(w_in_data), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
      .credit_cnt(w_credit), .fifo_level(w_level), .overflow_err(w_ovf));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard state for the default instance
   logic [7:0] send_q[$];
   logic [7:0] exp_q[$];
   int  ready_mode = 1;   // 0 hold low, 1 hold high, 2 random
   bit  rand_valid = 0;
   bit  track_gap  = 0;
   int  cyc = 0, last_out = 0, n_hs = 0;

   task automatic run(input int n);
      logic [7:0] e;
      int sum;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         in_valid  = (send_q.size() > 0) && (!rand_valid || $urandom_range(0, 3) != 0);
         in_data   = (send_q.size() > 0) ? send_q[0] : 8'h00;
         out_ready = (ready_mode == 2) ? ($urandom_range(0, 1) == 1) : (ready_mode == 1);
         #1;
         if (in_valid && in_ready) begin
            exp_q.push_back(send_q.pop_front());
            n_hs++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'(out_data), 64'h100);
            end else begin
               e = exp_q.pop_front();
               chk("word_order", 64'(out_data), 64'(e));
               $display("word out %02h (expected %02h) cycle %0d", out_data, e, cyc);
            end
            if (track_gap && last_out > 0) chk("b2b_gap", cyc - last_out, 2);
            last_out = cyc;
         end
         // Conservation: every credit is either held, in the FIFO, or one return in flight.
         sum = int'(credit_cnt) + int'(fifo_level);
         if (sum != 8 && sum != 7) chk("credit_conservation", sum, 8);
         if (overflow_err) chk("no_overflow", 64'(overflow_err), 0);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic [7:0] exp_out;
      int         exp_lat;
      int         exp_lvl2;
      int         exp_cred2;
   } vec_t;
   vec_t vecs[5];

   initial begin
      int t, lat;
      bit seen0, seen1;
      int maxlvl;
      logic [31:0] wsend[$];
      logic [31:0] wexp[$];
      int wgot;

      vecs[0] = '{8'hA5, 8'hA5, 4, 1, 7};
      vecs[1] = '{8'h00, 8'h00, 4, 1, 7};
      vecs[2] = '{8'hFF, 8'hFF, 4, 1, 7};
      vecs[3] = '{8'h3C, 8'h3C, 4, 1, 7};
      vecs[4] = '{8'h96, 8'h96, 4, 1, 7};

      // ---- reset ----
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("in_ready_in_reset", 64'(in_ready), 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_out_data", 64'(out_data), 0);
      chk("rst_credit", 64'(credit_cnt), 8);
      chk("rst_level", 64'(fifo_level), 0);
      chk("rst_overflow", 64'(overflow_err), 0);
      chk("rst_c1_credit", 64'(c1_credit), 1);
      chk("rst_w_credit", 64'(w_credit), 4);

      // ---- table vectors: single words, latency and early occupancy ----
      foreach (vecs[k]) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = vecs[k].data; out_ready = 1'b1;
         #1;
         chk("tbl_in_ready", 64'(in_ready), 1);
         lat = 99;
         for (t = 1; t <= 20; t++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (t == 2) begin
               chk("tbl_level_t2", 64'(fifo_level), vecs[k].exp_lvl2);
               chk("tbl_credit_t2", 64'(credit_cnt), vecs[k].exp_cred2);
            end
            if (out_valid) begin
               lat = t;
               break;
            end
         end
         chk("tbl_latency", lat, vecs[k].exp_lat);
         chk("tbl_data", 64'(out_data), 64'(vecs[k].exp_out));
         $display("vector %0d: sent %02h got %02h latency %0d", k, vecs[k].data, out_data, lat);
         repeat (4) @(negedge clk);
         #1;
         chk("tbl_credit_back", 64'(credit_cnt), 8);
      end

      // ---- back-to-back 0x01..0x10 ----
      for (int i = 1; i <= 16; i++) send_q.push_back(8'(i));
      ready_mode = 1; track_gap = 1; last_out = 0; n_hs = 0;
      run(45);
      track_gap = 0;
      chk("b2b_handshakes", n_hs, 16);
      chk("b2b_drained", exp_q.size(), 0);

      // ---- backpressure: 6 words with out_ready low ----
      for (int i = 0; i < 6; i++) send_q.push_back(8'($urandom));
      ready_mode = 0; n_hs = 0;
      run(30);
      chk("bp_level_full", 64'(fifo_level), 8);
      chk("bp_credit_zero", 64'(credit_cnt), 0);
      chk("bp_in_ready_low", 64'(in_ready), 0);
      chk("bp_no_overflow", 64'(overflow_err), 0);
      chk("bp_handshakes", n_hs, 6);
      ready_mode = 1;
      run(30);
      chk("bp_drained", exp_q.size(), 0);
      chk("bp_credit_back", 64'(credit_cnt), 8);

      // ---- reset in the middle of 0x77 ----
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_level_beat0", 64'(fifo_level), 1);
      rst = 1'b1;
      #1;
      chk("mid_in_ready_rst", 64'(in_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_level_cleared", 64'(fifo_level), 0);
      chk("mid_credit_restored", 64'(credit_cnt), 8);
      send_q.delete(); exp_q.delete();
      run(6);   // any out_valid here is reported as an unexpected word
      chk("mid_no_out_valid", 64'(out_valid), 0);
      send_q.push_back(8'h12);
      run(10);
      chk("mid_next_word", exp_q.size(), 0);

      // ---- randomized traffic against the scoreboard ----
      for (int i = 0; i < 40; i++) send_q.push_back(8'($urandom));
      ready_mode = 2; rand_valid = 1;
      run(400);
      ready_mode = 1; rand_valid = 0;
      run(40);
      chk("rnd_all_sent", send_q.size(), 0);
      chk("rnd_all_received", exp_q.size(), 0);
      chk("rnd_credit_back", 64'(credit_cnt), 8);

      // ---- credit starvation, CREDITS=1 ----
      @(negedge clk);
      c1_in_valid = 1'b1; c1_in_data = 8'h3C; c1_out_ready = 1'b1;
      #1;
      chk("c1_in_ready", 64'(c1_in_ready), 1);
      seen0 = 0; seen1 = 0; maxlvl = 0; lat = 99;
      for (t = 1; t <= 30; t++) begin
         @(negedge clk);
         c1_in_valid = 1'b0;
         #1;
         if (int'(c1_level) > maxlvl) maxlvl = int'(c1_level);
         if (c1_credit == 4'd0) seen0 = 1;
         if (c1_credit == 4'd1) seen1 = 1;
         if (c1_credit > 4'd1) chk("c1_credit_bound", 64'(c1_credit), 1);
         if (c1_out_valid) begin
            lat = t;
            break;
         end
      end
      chk("c1_data", 64'(c1_out_data), 64'h3C);
      chk("c1_max_level", maxlvl, 1);
      chk("c1_credit_toggled", 64'(seen0 && seen1), 1);
      $display("credit1 word %02h after %0d cycles", c1_out_data, lat);

      // ---- wide configuration ----
      @(negedge clk);
      w_in_valid = 1'b1; w_in_data = 32'hDEADBEEF; w_out_ready = 1'b1;
      #1;
      chk("w_in_ready", 64'(w_in_ready), 1);
      lat = 99;
      for (t = 1; t <= 20; t++) begin
         @(negedge clk);
         w_in_valid = 1'b0;
         #1;
         if (w_out_valid) begin
            lat = t;
            break;
         end
      end
      chk("w_latency", lat, 6);
      chk("w_data", 64'(w_out_data), 64'hDEADBEEF);
      $display("wide word %08h latency %0d", w_out_data, lat);

      for (int i = 0; i < 10; i++) wsend.push_back($urandom);
      wgot = 0;
      for (int c = 0; c < 120 && wgot < 10; c++) begin
         @(negedge clk);
         w_in_valid = (wsend.size() > 0);
         w_in_data  = (wsend.size() > 0) ? wsend[0] : 32'h0;
         #1;
         if (w_in_valid && w_in_ready) wexp.push_back(wsend.pop_front());
         if (w_out_valid && w_out_ready) begin
            if (wexp.size() == 0) begin
               chk("w_unexpected", 64'(w_out_data), 64'h1_0000_0000);
            end else begin
               chk("w_word_order", 64'(w_out_data), 64'(wexp[0]));
               $display("wide word out %08h (expected %08h)", w_out_data, wexp[0]);
               void'(wexp.pop_front());
            end
            wgot++;
         end
      end
      chk("w_words_received", wgot, 10);
      @(negedge clk);
      w_in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("w_credit_back", 64'(w_credit), 4);
      chk("w_level_empty", 64'(w_level), 0);
      chk("w_no_overflow", 64'(w_ovf), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
